// File: rtl/key_bounce_emulator_pkg.sv
// bounce_pkg: shared FSM states, LFSR taps and widths for the key bounce emulator
package bounce_pkg;
    typedef enum logic [2:0] {UP, BOUNCE_DN, SETTLE_DN, DOWN, BOUNCE_UP, SETTLE_UP} state_t;
    localparam int LFSR_W = 16;
    localparam int CNT_W = 16;
    localparam int EDGE_W = 5;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/key_bounce_emulator_lfsr16.sv
// lfsr16: 16-bit right-shift Galois LFSR that advances only when step is high
module lfsr16
    import bounce_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);
    always_ff @(posedge clk) begin
        if (!reset_n) value <= seed;
        else if (step) value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
    end
endmodule

// File: rtl/key_bounce_emulator.sv
// key_bounce_emulator: turns a clean press/release level into a bouncy active-low key waveform
module key_bounce_emulator
    import bounce_pkg::*;
#(
    parameter int              BOUNCES   = 3,
    parameter int              MIN_SEG   = 4,
    parameter int              SEG_W     = 3,
    parameter int              SETTLE    = 20,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              press,
    output logic              key_out,
    output logic              busy,
    output logic              done_tick,
    output logic [EDGE_W-1:0] edge_cnt
);
    localparam logic [CNT_W-1:0] SEG_MASK = CNT_W'((1 << SEG_W) - 1);
    localparam logic [CNT_W-1:0] SEG_BASE = CNT_W'(MIN_SEG - 1);
    localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [EDGE_W-1:0] LAST_TOG = EDGE_W'(2 * BOUNCES - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] seg_cnt, seg_nx, set_cnt, set_nx, seg_len;
    logic [EDGE_W-1:0] tog_cnt, tog_nx, edge_nx;
    logic [LFSR_W-1:0] lfsr;
    logic key_nx, done_nx, step;
    lfsr16 u_lfsr (
        .clk(clk),
        .reset_n(reset_n),
        .step(step),
        .seed(LFSR_SEED),
        .value(lfsr)
    );
    // timers hold length-1 so a segment of L cycles toggles on the L-th edge after its load
    assign seg_len = SEG_BASE + (lfsr & SEG_MASK);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= UP;
            key_out   <= 1'b1;
            seg_cnt   <= '0;
            set_cnt   <= '0;
            tog_cnt   <= '0;
            edge_cnt  <= '0;
            done_tick <= 1'b0;
        end else begin
            state     <= state_nx;
            key_out   <= key_nx;
            seg_cnt   <= seg_nx;
            set_cnt   <= set_nx;
            tog_cnt   <= tog_nx;
            edge_cnt  <= edge_nx;
            done_tick <= done_nx;
        end
    end
    always_comb begin
        state_nx = state;
        key_nx   = key_out;
        seg_nx   = seg_cnt;
        set_nx   = set_cnt;
        tog_nx   = tog_cnt;
        edge_nx  = edge_cnt;
        done_nx  = 1'b0;
        step     = 1'b0;
        case (state)
            UP, DOWN: begin
                if (press == (state == UP)) begin
                    key_nx  = ~key_out;
                    edge_nx = EDGE_W'(1);
                    tog_nx  = '0;
                    if (BOUNCES == 0) begin
                        state_nx = (state == UP) ? SETTLE_DN : SETTLE_UP;
                        set_nx   = SET_LOAD;
                    end else begin
                        state_nx = (state == UP) ? BOUNCE_DN : BOUNCE_UP;
                        seg_nx   = seg_len;
                        step     = 1'b1;
                    end
                end
            end
            BOUNCE_DN, BOUNCE_UP: begin
                if (seg_cnt == '0) begin
                    key_nx  = ~key_out;
                    edge_nx = edge_cnt + 1'b1;
                    tog_nx  = tog_cnt + 1'b1;
                    if (tog_cnt == LAST_TOG) begin
                        state_nx = (state == BOUNCE_DN) ? SETTLE_DN : SETTLE_UP;
                        set_nx   = SET_LOAD;
                    end else begin
                        seg_nx = seg_len;
                        step   = 1'b1;
                    end
                end else begin
                    seg_nx = seg_cnt - 1'b1;
                end
            end
            default: begin
                if (set_cnt == '0) begin
                    state_nx = (state == SETTLE_DN) ? DOWN : UP;
                    done_nx  = 1'b1;
                end else begin
                    set_nx = set_cnt - 1'b1;
                end
            end
        endcase
    end
    always_comb busy = (state != UP) && (state != DOWN);
endmodule

// File: tb/tb_key_bounce_emulator.sv
// tb_key_bounce_emulator: timeline-based reference model plus directed and random press/reset stimulus
module tb_key_bounce_emulator;
    localparam int B = 3;
    localparam int MS = 4;
    localparam int SW = 3;
    localparam int ST = 20;
    localparam logic [15:0] SEED = 16'hACE1;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic press = 1'b0;
    logic key_out, busy, done_tick, key0, busy0, done0;
    logic [4:0] edge_cnt, edge0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lit[6] = '{5, 4, 4, 8, 10, 11};
    always #5 clk = ~clk;
    key_bounce_emulator #(.BOUNCES(B), .MIN_SEG(MS), .SEG_W(SW), .SETTLE(ST), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset_n(reset_n), .press(press), .key_out(key_out),
        .busy(busy), .done_tick(done_tick), .edge_cnt(edge_cnt)
    );
    key_bounce_emulator #(.BOUNCES(0), .MIN_SEG(MS), .SEG_W(SW), .SETTLE(ST), .LFSR_SEED(SEED)) dut0 (
        .clk(clk), .reset_n(reset_n), .press(press), .key_out(key0),
        .busy(busy0), .done_tick(done0), .edge_cnt(edge0)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction
    // Model: at each event start the whole edge timeline is drawn from the LFSR up front
    bit m_key = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_down = 1'b0, armed = 1'b0;
    int m_edges = 0, t_done = 0;
    int t_edges[$];
    logic [15:0] m_lfsr = SEED;
    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        if (!reset_n) begin
            armed = 1'b1; m_key = 1'b1; m_busy = 1'b0; m_down = 1'b0; m_edges = 0;
            m_lfsr = SEED; t_edges.delete();
        end else if (!m_busy) begin
            if (press != m_down) begin
                int t;
                t = cyc;
                m_busy = 1'b1; m_down = press; m_key = !press; m_edges = 1;
                for (int k = 0; k < 2 * B; k++) begin
                    t += MS + int'(m_lfsr[SW-1:0]);
                    m_lfsr = lfsr_next(m_lfsr);
                    t_edges.push_back(t);
                end
                t_done = t + ST;
            end
        end else if (t_edges.size() > 0 && t_edges[0] == cyc) begin
            void'(t_edges.pop_front());
            m_key = !m_key;
            m_edges++;
        end else if (cyc == t_done) begin
            m_busy = 1'b0;
            m_done = 1'b1;
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("key_out", 32'(key_out), 32'(m_key));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done_tick", 32'(done_tick), 32'(m_done));
            chk("edge_cnt", 32'(edge_cnt), 32'(m_edges));
        end
    end
    logic prev_key = 1'b1;
    int e_q[$];
    int d0_cyc = -1;
    always @(negedge clk) begin
        if (key_out !== prev_key) e_q.push_back(cyc);
        prev_key = key_out;
        if (done0 === 1'b1) d0_cyc = cyc;
    end
    task automatic step_cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask
    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (done_tick === 1'b1) begin dc = cyc; return; end
        end
        checks++;
        failures++;
        $display("FAIL done_timeout: no done_tick within 300 cycles (cycle %0d)", cyc);
    endtask
    initial begin
        int d, st;
        int run1[$];
        reset_n = 1'b0; press = 1'b1;
        step_cycles(5);
        chk("reset key_out", 32'(key_out), 32'd1);
        chk("reset edge_cnt", 32'(edge_cnt), 32'd0);
        // press event straight out of reset
        e_q.delete();
        reset_n = 1'b1;
        st = cyc + 1;
        wait_done(d);
        chk("press edges", 32'(e_q.size()), 32'd7);
        chk("press first edge", 32'(e_q.size() > 0 ? e_q[0] : -1), 32'(st));
        for (int i = 0; i < 6; i++)
            chk("press width", 32'(e_q.size() > i + 1 ? e_q[i+1] - e_q[i] : -1), 32'(lit[i]));
        chk("press settle", 32'(e_q.size() == 7 ? d - e_q[6] : -1), 32'd20);
        chk("press edge_cnt", 32'(edge_cnt), 32'd7);
        chk("press key_out", 32'(key_out), 32'd0);
        chk("press busy", 32'(busy), 32'd0);
        chk("b0 done delay", 32'(d0_cyc - st), 32'd20);
        chk("b0 edge_cnt", 32'(edge0), 32'd1);
        chk("b0 key_out", 32'(key0), 32'd0);
        foreach (e_q[i]) run1.push_back(e_q[i] - e_q[0]);
        // release event
        e_q.delete();
        press = 1'b0;
        wait_done(d);
        chk("release edges", 32'(e_q.size()), 32'd7);
        chk("release key_out", 32'(key_out), 32'd1);
        chk("release edge_cnt", 32'(edge_cnt), 32'd7);
        // press then release mid-bounce
        e_q.delete();
        press = 1'b1;
        step_cycles(3);
        press = 1'b0;
        wait_done(d);
        chk("queued press key_out", 32'(key_out), 32'd0);
        step_cycles(2);
        chk("queued release start", 32'(e_q.size() > 7 ? e_q[7] : -1), 32'(d + 1));
        wait_done(d);
        chk("queued release key_out", 32'(key_out), 32'd1);
        // reset during the third segment, then rerun the first press
        e_q.delete();
        press = 1'b1;
        for (int i = 0; i < 100 && e_q.size() < 3; i++) step_cycles(1);
        chk("third segment reached", 32'(e_q.size()), 32'd3);
        step_cycles(1);
        reset_n = 1'b0;
        step_cycles(1);
        chk("abort key_out", 32'(key_out), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        e_q.delete();
        reset_n = 1'b1;
        st = cyc + 1;
        wait_done(d);
        chk("rerun edges", 32'(e_q.size()), 32'd7);
        chk("rerun first edge", 32'(e_q.size() > 0 ? e_q[0] : -1), 32'(st));
        for (int i = 1; i < 7; i++)
            chk("rerun offset", 32'(e_q.size() > i ? e_q[i] - e_q[0] : -1), 32'(run1.size() > i ? run1[i] : -2));
        // random press levels and occasional resets, checked every cycle by the model
        for (int n = 0; n < 60; n++) begin
            press = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                reset_n = 1'b0;
                step_cycles($urandom_range(1, 3));
                reset_n = 1'b1;
            end
            step_cycles($urandom_range(1, 90));
        end
        press = 1'b0;
        step_cycles(200);
        chk("final key_out", 32'(key_out), 32'd1);
        chk("final busy", 32'(busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
